// File: rtl/pdm_cic_pkg.sv
// pdm_cic_pkg: shared types and helpers for the PDM CIC sequencer
// Contents: serialiser state enum, channel-index width helper.
package pdm_cic_pkg;

    typedef enum logic {IDLE, SEND} seq_state_t;

    // Width of an index over n items, never less than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: PDM microphone clock divider and per-edge CIC step strobes
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   enable    run the divider; when low the clock parks at 0 and no strobes fire
//   pdm_clk   registered microphone clock, period 2*CLK_DIV cycles
//   ena_hi    one-cycle pulse after the last cycle of the high phase
//   ena_lo    one-cycle pulse after the last cycle of the low phase
module pdm_clk_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic pdm_clk,
    output logic ena_hi,
    output logic ena_lo
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    logic          wrap;

    always_comb wrap = div == DW'(CLK_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            div     <= '0;
            pdm_clk <= 1'b0;
            ena_hi  <= 1'b0;
            ena_lo  <= 1'b0;
        end else if (!enable) begin
            div     <= '0;
            pdm_clk <= 1'b0;
            ena_hi  <= 1'b0;
            ena_lo  <= 1'b0;
        end else begin
            div     <= wrap ? '0 : div + DW'(1);
            pdm_clk <= wrap ? ~pdm_clk : pdm_clk;
            // pdm_clk holds the phase that is ending, so the strobes are exclusive
            ena_hi  <= wrap && pdm_clk;
            ena_lo  <= wrap && !pdm_clk;
        end

endmodule

// File: rtl/pdm_cic_sequencer.sv
// pdm_cic_sequencer: PDM timing master, decimation strobe and frame serialiser for a CIC bank
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   enable                run the PDM clock and CIC strobes
//   pdm_clk, ena_hi/lo    microphone clock and CIC step strobes
//   ch_data               CIC outputs, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   out_data/chan/first   current stream word, its channel, start-of-frame marker
//   out_valid, out_ready  valid/ready stream handshake
//   overrun, clr_overrun  sticky dropped-frame flag and its synchronous clear
module pdm_cic_sequencer
    import pdm_cic_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int SAMPLE_W = 8,
    parameter int CLK_DIV  = 16,
    parameter int DECIM    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     pdm_clk,
    output logic                     ena_hi,
    output logic                     ena_lo,
    input  logic [N_CH*SAMPLE_W-1:0] ch_data,
    output logic [SAMPLE_W-1:0]      out_data,
    output logic [chan_w(N_CH)-1:0]  out_chan,
    output logic                     out_first,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    localparam int CW = chan_w(N_CH);
    localparam int DW = chan_w(DECIM);

    seq_state_t          state, state_n;
    logic [DW-1:0]       dec;
    logic [CW-1:0]       idx, idx_n;
    logic [SAMPLE_W-1:0] shadow [N_CH];
    logic                snap, dec_last, xfer, last, load, drop;

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .pdm_clk (pdm_clk),
        .ena_hi  (ena_hi),
        .ena_lo  (ena_lo)
    );

    always_comb begin
        dec_last = dec == DW'(DECIM - 1);
        xfer     = out_valid && out_ready;
        last     = idx == CW'(N_CH - 1);
        // a snapshot landing on the final transfer starts the next frame back-to-back
        load     = snap && (state == IDLE || (xfer && last));
        drop     = snap && !load;
        idx_n    = last ? '0 : idx + CW'(1);
    end

    // snap trails the dec wrap by one cycle so the CIC output register has settled
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dec  <= '0;
            snap <= 1'b0;
        end else begin
            snap <= ena_lo && dec_last;
            if (ena_lo) dec <= dec_last ? '0 : dec + DW'(1);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        if (load)              state_n = SEND;
        else if (xfer && last) state_n = IDLE;
    end

    always_comb out_valid = state == SEND;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_chan  <= '0;
            out_first <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < N_CH; i++) shadow[i] <= ch_data[i*SAMPLE_W +: SAMPLE_W];
                idx       <= '0;
                out_data  <= ch_data[SAMPLE_W-1:0];
                out_chan  <= '0;
                out_first <= 1'b1;
            end else if (xfer) begin
                idx       <= idx_n;
                out_data  <= shadow[idx_n];
                out_chan  <= idx_n;
                out_first <= 1'b0;
            end
            // a drop in the same cycle as a clear leaves the flag set
            overrun <= drop | (overrun & ~clr_overrun);
        end

endmodule

// File: doc/pdm_cic_sequencer.md
# pdm_cic_sequencer

Timing master and output scheduler for the microphone-grid CIC decimators. It derives the PDM microphone clock from the system clock and issues the per-edge `ena` strobes that step every CIC instance. It counts PDM periods to form the decimation strobe, snapshots all channel results on that strobe, and serialises them as one frame over a valid/ready stream. It sits between the CIC bank and the downstream packer/FIFO.

## Interface
- `N_CH`, 8, number of CIC channels (≥1)
- `SAMPLE_W`, 8, width of one CIC result, equal to the CIC `OUT_SIZE`
- `CLK_DIV`, 16, number of `clk` cycles per PDM half-period (≥2)
- `DECIM`, 32, number of PDM periods per output frame (≥1)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run the PDM clock and the strobes
- `pdm_clk`  out  1  microphone clock, registered
- `ena_hi`  out  1  one-cycle CIC step strobe for the high-phase microphones
- `ena_lo`  out  1  one-cycle CIC step strobe for the low-phase microphones
- `ch_data`  in  N_CH*SAMPLE_W  CIC `dout` bus, concatenated; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
- `out_data`  out  SAMPLE_W  current sample
- `out_chan`  out  $clog2(N_CH) (min 1)  channel index of `out_data`
- `out_first`  out  1  high with channel 0 of each frame
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `overrun`  out  1  sticky flag: a frame was dropped
- `clr_overrun`  in  1  synchronous clear of `overrun`

## Operation
- **Divider.** Counter `div` runs 0..CLK_DIV-1 while `enable`=1.
  - When `div` wraps, `pdm_clk` toggles.
  - When `enable`=0, `div` is forced to 0, `pdm_clk` to 0, and no strobes are issued.
- **Strobes.**
  - `ena_hi` = registered pulse for (`div`==CLK_DIV-1 && `pdm_clk`==1): the last cycle of the high phase.
  - `ena_lo` = the same for the low phase.
  - The two strobes are never high together.
- **Decimation.**
  - Counter `dec` (0..DECIM-1) increments on each `ena_lo` and wraps at DECIM-1.
  - The wrap generates `strobe`.
  - `snap` = `strobe` delayed 1 cycle. This covers the CIC output register latency.
- **Snapshot.** On `snap`, all of `ch_data` is copied into a shadow buffer of N_CH words.
- **Serialiser FSM.**
  - **IDLE**, on `snap`: load the shadow buffer, set idx=0, go to SEND.
  - **SEND**: `out_valid`=1, `out_data`=buf[idx], `out_chan`=idx, `out_first`=(idx==0).
    - A transfer occurs when `out_valid` && `out_ready`. On a transfer, idx increments.
    - A transfer with idx==N_CH-1 returns the FSM to IDLE.
    - `out_data`, `out_chan` and `out_first` stay stable while `out_valid` && !`out_ready`.
  - `snap` in SEND, except on the final transfer: the new snapshot is discarded, `overrun` is set, and the current frame continues unchanged.
  - `snap` in the same cycle as the final transfer: the new frame is loaded (SEND, idx=0) with no overrun.
- **Overrun flag.** `clr_overrun` clears `overrun`. If a set and a clear occur in the same cycle, the set wins.
- **Disable mid-operation.** Deasserting `enable` does not abort a frame in SEND; that frame completes normally.
- **Reset.** Asserting `rst` at any time returns the block to its reset state immediately.

## Timing
- Reset values: `pdm_clk`=0, `ena_hi`=0, `ena_lo`=0, `out_valid`=0, `out_data`=0, `out_chan`=0, `out_first`=0, `overrun`=0; `div`=0, `dec`=0; FSM in IDLE.
- `pdm_clk` period = 2*CLK_DIV cycles.
- Frame period = 2*CLK_DIV*DECIM cycles.
- Latency:
  - `ena_lo` that wraps `dec` at cycle t → `snap` at t+1 (capture edge) → `out_valid` high at t+2.
- Sustained operation needs `out_ready` duty high enough to move N_CH words per frame period; otherwise `overrun` sets.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `pdm_cic_pkg` holds:
  - FSM state enum `seq_state_t` {IDLE, SEND}
  - function `chan_w(N_CH)` = max(1, $clog2(N_CH))
- Natural sub-module `pdm_clk_gen`: contains `div`, `pdm_clk`, `ena_hi` and `ena_lo`; parameter CLK_DIV; inputs `clk`, `rst`, `enable`.
- The top level holds the decimation counter, shadow buffer and serialiser.

## Test plan
Unless a scenario says otherwise, the bench uses N_CH=4, SAMPLE_W=8, CLK_DIV=2, DECIM=4.

1. Release reset, `enable`=1 → `pdm_clk` has period 4 cycles; `ena_hi` and `ena_lo` each pulse once per period, 2 cycles apart; every output was 0 during reset.
2. `ch_data`={8'h44,8'h33,8'h22,8'h11}, `out_ready`=1 → one frame every 16 cycles: 11/0/first, 22/1, 33/2, 44/3. `out_valid` rises 2 cycles after the 4th `ena_lo`.
3. `out_ready` toggles 1-0-1-0 → data and channel stay stable while stalled; all 4 words delivered; `overrun`=0.
4. `out_ready`=0 for 20 cycles → second `snap` sets `overrun`=1; first frame still delivered intact; `clr_overrun` pulse → 0.
5. Hold `out_ready` so the final transfer (chan 3) coincides with `snap` → new frame starts at chan 0 the next cycle; `overrun`=0.
6. Assert `rst` mid-frame at chan 2, and separately drop `enable` mid-frame → reset: all outputs 0 immediately; disable: frame completes, `pdm_clk` held at 0, no further strobes.
